// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
// rf_cmd_t is sized by the package widths, which are also the arbiter's default widths.
package regfile_arb_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  function automatic int id_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

  typedef struct packed {
    logic                     wen;
    logic [RF_ADDR_WIDTH-1:0] wad;
    logic [RF_DATA_WIDTH-1:0] din;
    logic                     ren1;
    logic [RF_ADDR_WIDTH-1:0] rad1;
    logic                     ren2;
    logic [RF_ADDR_WIDTH-1:0] rad2;
  } rf_cmd_t;

endpackage

// File: rtl/regfile_grant_picker.sv
// Combinational round-robin scan that grants up to two reads and one write
// with no address overlap between any of the granted operations.
module regfile_grant_picker
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int IDW        = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
  input  logic [IDW-1:0]                i_rr_ptr,
  output logic [NUM_REQ-1:0]            o_grant,
  output rf_cmd_t                       o_cmd,
  output logic [IDW-1:0]                o_rd1_id,
  output logic [IDW-1:0]                o_rd2_id,
  output logic                          o_any_grant,
  output logic [IDW-1:0]                o_first_id
);

  always_comb begin
    logic [IDW-1:0]        w_idx;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_hit;
    o_grant     = '0;
    o_cmd       = '0;
    o_rd1_id    = '0;
    o_rd2_id    = '0;
    o_any_grant = 1'b0;
    o_first_id  = '0;
    w_idx       = '0;
    w_addr      = '0;
    w_hit       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // NUM_REQ is a power of two, so the IDW-bit sum wraps modulo NUM_REQ.
      w_idx  = i_rr_ptr + IDW'(k);
      w_addr = i_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
      w_hit  = 1'b0;
      if (i_valid[w_idx]) begin
        if (i_we[w_idx]) begin
          if (!o_cmd.wen && !(o_cmd.ren1 && o_cmd.rad1 == w_addr) &&
              !(o_cmd.ren2 && o_cmd.rad2 == w_addr)) begin
            o_cmd.wen = 1'b1;
            o_cmd.wad = w_addr;
            o_cmd.din = i_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
            w_hit     = 1'b1;
          end
        end else if (!o_cmd.ren2 && !(o_cmd.wen && o_cmd.wad == w_addr) &&
                     !(o_cmd.ren1 && o_cmd.rad1 == w_addr)) begin
          if (!o_cmd.ren1) begin
            o_cmd.ren1 = 1'b1;
            o_cmd.rad1 = w_addr;
            o_rd1_id   = w_idx;
          end else begin
            o_cmd.ren2 = 1'b1;
            o_cmd.rad2 = w_addr;
            o_rd2_id   = w_idx;
          end
          w_hit = 1'b1;
        end
      end
      if (w_hit) begin
        o_grant[w_idx] = 1'b1;
        if (!o_any_grant) begin
          o_any_grant = 1'b1;
          o_first_id  = w_idx;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a 2-read/1-write register file among NUM_REQ requesters and routes
// read data back to the owning requester one cycle after issue.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  // Request i transfers on i_req_valid[i] && o_req_ready[i]; ready is a
  // combinational function of valid, so valid must never wait on ready and
  // an unaccepted request keeps its fields stable.
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] o_rsp_data,
  output logic [DATA_WIDTH-1:0]         o_rf_din,
  output logic [ADDR_WIDTH-1:0]         o_rf_wad1,
  output logic [ADDR_WIDTH-1:0]         o_rf_rad1,
  output logic [ADDR_WIDTH-1:0]         o_rf_rad2,
  output logic                          o_rf_wen1,
  output logic                          o_rf_ren1,
  output logic                          o_rf_ren2,
  input  logic [DATA_WIDTH-1:0]         i_rf_dout1,
  input  logic [DATA_WIDTH-1:0]         i_rf_dout2,
  input  logic                          i_rf_collision,
  output logic                          o_err_collision
);

  localparam int IDW = id_width(NUM_REQ);

  logic [IDW-1:0]     r_rr_ptr;
  logic               r_rd1_vld;
  logic               r_rd2_vld;
  logic [IDW-1:0]     r_rd1_id;
  logic [IDW-1:0]     r_rd2_id;
  logic               r_err;

  logic [NUM_REQ-1:0] w_valid;
  logic [NUM_REQ-1:0] w_grant;
  rf_cmd_t            w_cmd;
  logic [IDW-1:0]     w_rd1_id;
  logic [IDW-1:0]     w_rd2_id;
  logic               w_any_grant;
  logic [IDW-1:0]     w_first_id;

  // Masking valid during reset keeps every grant and port enable low.
  assign w_valid = resetn ? i_req_valid : '0;

  regfile_grant_picker #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDW        (IDW)
  ) u_picker (
    .i_valid     (w_valid),
    .i_we        (i_req_we),
    .i_addr      (i_req_addr),
    .i_wdata     (i_req_wdata),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_cmd       (w_cmd),
    .o_rd1_id    (w_rd1_id),
    .o_rd2_id    (w_rd2_id),
    .o_any_grant (w_any_grant),
    .o_first_id  (w_first_id)
  );

  assign o_req_ready     = w_grant;
  assign o_rf_wen1       = w_cmd.wen;
  assign o_rf_wad1       = w_cmd.wad;
  assign o_rf_din        = w_cmd.din;
  assign o_rf_ren1       = w_cmd.ren1;
  assign o_rf_rad1       = w_cmd.rad1;
  assign o_rf_ren2       = w_cmd.ren2;
  assign o_rf_rad2       = w_cmd.rad2;
  assign o_err_collision = r_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rr_ptr  <= '0;
      r_rd1_vld <= 1'b0;
      r_rd2_vld <= 1'b0;
      r_rd1_id  <= '0;
      r_rd2_id  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_any_grant) begin
        r_rr_ptr <= w_first_id + IDW'(1);
      end
      r_rd1_vld <= w_cmd.ren1;
      r_rd2_vld <= w_cmd.ren2;
      r_rd1_id  <= w_rd1_id;
      r_rd2_id  <= w_rd2_id;
      if (i_rf_collision) begin
        r_err <= 1'b1;
      end
    end
  end

  // Gating with resetn drops any response that was in flight when reset hit.
  always_comb begin
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    if (resetn) begin
      if (r_rd1_vld) begin
        o_rsp_valid[r_rd1_id]                        = 1'b1;
        o_rsp_data[r_rd1_id*DATA_WIDTH +: DATA_WIDTH] = i_rf_dout1;
      end
      if (r_rd2_vld) begin
        o_rsp_valid[r_rd2_id]                        = 1'b1;
        o_rsp_data[r_rd2_id*DATA_WIDTH +: DATA_WIDTH] = i_rf_dout2;
      end
    end
  end

endmodule
